div_issue_ctrl: RTL and testbench



---
 rtl/div_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_div_issue_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Request-side controller for the fixed-latency divider: issues operands, tracks ops
// through the divider latency, and collects quotients into an in-order result FIFO.
module div_issue_ctrl #(
    parameter int LATENCY    = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int TAGW       = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_num,
    input  logic [21:0]     req_den,
    input  logic [TAGW-1:0] req_tag,
    output logic [31:0]     div_numerator,
    output logic [21:0]     div_denominator,
    input  logic [19:0]     div_result,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [19:0]     res_quot,
    output logic [TAGW-1:0] res_tag,
    output logic            res_dz
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;

    logic [LATENCY:1]           r_vld_pipe;
    logic [LATENCY:1][TAGW-1:0] r_tag_pipe;
    logic [LATENCY:1]           r_dz_pipe;
    logic [LATENCY:1]           r_sat_pipe;

    logic [19:0]     r_mem_quot [FIFO_DEPTH];
    logic [TAGW-1:0] r_mem_tag  [FIFO_DEPTH];
    logic            r_mem_dz   [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;

    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_den_zero;
    logic [19:0]     w_push_quot;
    logic [CW-1:0]   w_inflight;
    logic [CW-1:0]   w_occ;

    assign w_den_zero      = (req_den == 22'd0);
    assign div_numerator   = req_num;
    assign div_denominator = w_den_zero ? 22'd1 : req_den;

    // Credits cover both the FIFO contents and every op still inside the divider,
    // so a result leaving the divider always has a free FIFO slot.
    always_comb begin
        w_inflight = '0;
        for (int k = 1; k <= LATENCY; k++) begin
            w_inflight = w_inflight + CW'(r_vld_pipe[k]);
        end
    end

    assign w_occ     = CW'(r_count) + w_inflight;
    assign req_ready = !reset && (w_occ < CW'(FIFO_DEPTH));
    assign w_fire    = req_valid && req_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_pipe <= '0;
        end else begin
            for (int k = LATENCY; k >= 2; k--) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
            end
            r_vld_pipe[1] <= w_fire;
        end
    end

    always_ff @(posedge clock) begin
        for (int k = LATENCY; k >= 2; k--) begin
            r_tag_pipe[k] <= r_tag_pipe[k-1];
            r_dz_pipe[k]  <= r_dz_pipe[k-1];
            r_sat_pipe[k] <= r_sat_pipe[k-1];
        end
        r_tag_pipe[1] <= req_tag;
        r_dz_pipe[1]  <= w_den_zero;
        r_sat_pipe[1] <= req_num[31];
    end

    // Zero-denominator ops saturate toward the sign of the numerator.
    assign w_push      = r_vld_pipe[LATENCY];
    assign w_push_quot = !r_dz_pipe[LATENCY] ? div_result :
                         (r_sat_pipe[LATENCY] ? 20'h80000 : 20'h7FFFF);
    assign w_pop       = res_ready && (r_count != '0);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_quot[r_wr_ptr] <= w_push_quot;
            r_mem_tag[r_wr_ptr]  <= r_tag_pipe[LATENCY];
            r_mem_dz[r_wr_ptr]   <= r_dz_pipe[LATENCY];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head fields are masked when empty so the outputs read zero out of reset.
    assign res_valid = (r_count != '0);
    assign res_quot  = res_valid ? r_mem_quot[r_rd_ptr] : '0;
    assign res_tag   = res_valid ? r_mem_tag[r_rd_ptr]  : '0;
    assign res_dz    = res_valid ? r_mem_dz[r_rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed steps plus random traffic against a transaction-level
// model (outstanding-op credit count and a queue of timestamped expected results).
module tb_div_issue_ctrl;

    localparam int L = 5;
    localparam int D = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_num;
    logic [21:0] req_den;
    logic [3:0]  req_tag;
    logic [31:0] div_numerator;
    logic [21:0] div_denominator;
    logic [19:0] div_result;
    logic        res_valid;
    logic        res_ready;
    logic [19:0] res_quot;
    logic [3:0]  res_tag;
    logic        res_dz;

    div_issue_ctrl #(.LATENCY(L), .FIFO_DEPTH(D), .TAGW(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_num(req_num), .req_den(req_den), .req_tag(req_tag),
        .div_numerator(div_numerator), .div_denominator(div_denominator),
        .div_result(div_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_quot(res_quot), .res_tag(res_tag), .res_dz(res_dz)
    );

    always #5 clock = ~clock;

    // Stand-in for the external divider: L-cycle pipe of truncating signed division.
    logic [19:0] dpipe [L];
    always @(posedge clock) begin
        longint n, d, q;
        n = longint'($signed(div_numerator));
        d = longint'($signed(div_denominator));
        q = (d == 0) ? 0 : n / d;
        for (int k = L - 1; k >= 1; k--) dpipe[k] <= dpipe[k-1];
        dpipe[0] <= q[19:0];
    end
    assign div_result = dpipe[L-1];

    typedef struct {
        int          arr;
        logic [19:0] quot;
        logic [3:0]  tag;
        logic        dz;
    } exp_t;

    exp_t expq[$];
    int   outst = 0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h cyc=%0d", nm, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] n, input logic [21:0] d, input logic [3:0] t);
        exp_t   e;
        longint ln, ld, qq;
        e.arr = cyc + L + 1;
        e.tag = t;
        e.dz  = (d == 22'd0);
        if (e.dz) begin
            e.quot = n[31] ? 20'h80000 : 20'h7FFFF;
        end else begin
            ln = longint'($signed(n));
            ld = longint'($signed(d));
            qq = ln / ld;
            e.quot = qq[19:0];
        end
        return e;
    endfunction

    // One clock cycle: drive, check combinational outputs mid-cycle, update the model.
    task automatic step(input logic v, input logic [31:0] n, input logic [21:0] d,
                        input logic [3:0] t, input logic rr, input logic rs);
        logic exp_rdy, exp_rv;
        exp_t h;
        req_valid = v; req_num = n; req_den = d; req_tag = t;
        res_ready = rr; reset = rs;
        @(negedge clock);
        exp_rdy = !rs && (outst < D);
        exp_rv  = !rs && (expq.size() > 0) && (expq[0].arr <= cyc);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("res_valid", 32'(res_valid), 32'(exp_rv));
        chk("div_num", div_numerator, n);
        chk("div_den", 32'(div_denominator), (d == 22'd0) ? 32'd1 : 32'(d));
        if (rs) begin
            chk("rst_quot", 32'(res_quot), 32'd0);
            chk("rst_tag", 32'(res_tag), 32'd0);
            chk("rst_dz", 32'(res_dz), 32'd0);
            expq.delete();
            outst = 0;
        end else begin
            if (rr && exp_rv && res_valid) begin
                h = expq.pop_front();
                outst--;
                chk("res_quot", 32'(res_quot), 32'(h.quot));
                chk("res_tag", 32'(res_tag), 32'(h.tag));
                chk("res_dz", 32'(res_dz), 32'(h.dz));
            end
            if (v && exp_rdy && req_ready) begin
                expq.push_back(model(n, d, t));
                outst++;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int ncyc, input logic rr);
        for (int i = 0; i < ncyc; i++) step(1'b0, 32'd0, 22'd3, 4'd0, rr, 1'b0);
    endtask

    task automatic drain();
        int budget = 40;
        while (expq.size() > 0 && budget > 0) begin
            step(1'b0, 32'd0, 22'd3, 4'd0, 1'b1, 1'b0);
            budget--;
        end
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        // reset values
        step(1'b0, 32'd0, 22'd0, 4'd0, 1'b0, 1'b1);
        step(1'b1, 32'd9, 22'd0, 4'd1, 1'b1, 1'b1);

        // basic, including signed truncation
        step(1'b1, 32'd100, 22'd7, 4'd3, 1'b1, 1'b0);
        idle(7, 1'b1);
        step(1'b1, -32'sd100, 22'd7, 4'd5, 1'b1, 1'b0);
        drain();

        // divide by zero and wrap
        step(1'b1, 32'd5, 22'd0, 4'd1, 1'b1, 1'b0);
        step(1'b1, -32'sd5, 22'd0, 4'd2, 1'b1, 1'b0);
        step(1'b1, 32'h00100000, 22'd1, 4'd7, 1'b1, 1'b0);
        step(1'b1, 32'h7FFFFFFF, 22'h3FFFFF, 4'd8, 1'b1, 1'b0);
        drain();

        // streaming, 16 back-to-back
        for (int i = 0; i < 16; i++)
            step(1'b1, 32'(i * 1000 + 17), 22'(i + 2), 4'(i), 1'b1, 1'b0);
        drain();

        // backpressure: credits run out after 8, then a single pop frees one slot
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'(i * 77), 22'd3, 4'(i), 1'b0, 1'b0);
        idle(20, 1'b0);
        step(1'b0, 32'd0, 22'd3, 4'd0, 1'b1, 1'b0);
        step(1'b1, 32'd999, 22'd9, 4'd12, 1'b0, 1'b0);
        step(1'b1, 32'd999, 22'd9, 4'd13, 1'b0, 1'b0);
        drain();

        // reset mid-flight: in-flight ops must vanish
        step(1'b1, 32'd11, 22'd2, 4'd4, 1'b1, 1'b0);
        step(1'b1, 32'd12, 22'd2, 4'd5, 1'b1, 1'b0);
        step(1'b1, 32'd13, 22'd2, 4'd6, 1'b1, 1'b0);
        idle(1, 1'b1);
        step(1'b0, 32'd0, 22'd3, 4'd0, 1'b1, 1'b1);
        idle(12, 1'b1);
        step(1'b1, 32'd81, 22'd9, 4'd9, 1'b1, 1'b0);
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [21:0] d;
            d = ($urandom_range(0, 7) == 0) ? 22'd0 : 22'($urandom);
            step(1'($urandom_range(0, 3) != 0), 32'($urandom), d, 4'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'b0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
